fpu_divsqrt: RTL

FPU_DIVSQRT -- requirements
Module: fpu_divsqrt

---
 rtl/fpu_divsqrt.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_divsqrt.sv
// Iterative floating-point divide / square-root unit: one quotient or root bit per cycle,
// with an unnormalised result and sticky bit held in a valid/ack handshake until consumed.
module fpu_divsqrt #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned DEST_W = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fpu_start,
    input  logic                      fpu_op,
    input  logic [EXP_W+MANT_W:0]     fpu_a,
    input  logic [EXP_W+MANT_W:0]     fpu_b,
    input  logic [DEST_W-1:0]         fpu_dest,
    input  logic                      divsqrt_ack,
    output logic                      divsqrt_valid,
    output logic [MANT_W+3:0]         divsqrt_mantissa,
    output logic [EXP_W+1:0]          divsqrt_exponent,
    output logic                      divsqrt_sign,
    output logic [DEST_W-1:0]         divsqrt_dest,
    output logic [1:0]                divsqrt_special,
    output logic [1:0]                divsqrt_flags,
    output logic                      fpu_divsqrt_busy
);

    localparam int unsigned SW   = MANT_W + 1;
    localparam int unsigned QW   = MANT_W + 3;
    localparam int unsigned RW   = MANT_W + 6;
    localparam int unsigned DW   = 2 * MANT_W + 6;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned CW   = $clog2(MANT_W + 4);
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [1:0] SP_ZERO = 2'b01;
    localparam logic [1:0] SP_INF  = 2'b10;
    localparam logic [1:0] SP_NAN  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [SW-1:0]     divisor_q, divisor_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [DW-1:0]     rad_q, rad_d;
    logic [QW-1:0]     q_q, q_d;
    logic              valid_q, valid_d;
    logic [QW:0]       mant_q, mant_d;
    logic [EW-1:0]     exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [1:0]        special_q, special_d;
    logic [1:0]        flags_q, flags_d;

    // Operand field decode and classification (denormals read as zero)
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  fa, fb;
    logic               za, zb, ia, ib, na, nb;
    logic [SW-1:0]      ma, mb;

    assign {sa, ea, fa} = fpu_a;
    assign {sb, eb, fb} = fpu_b;
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == '1) && (fa == '0);
    assign ib = (eb == '1) && (fb == '0);
    assign na = (ea == '1) && (fa != '0);
    assign nb = (eb == '1) && (fb != '0);
    assign ma = {1'b1, fa};
    assign mb = {1'b1, fb};

    // Result exponents; the sqrt halving must stay a signed shift
    logic signed [EW-1:0] bias_s, e_div, e_unb, e_half, e_sqrt;
    logic [SW:0]          x_sqrt;
    logic [DW-1:0]        rad_init;

    assign bias_s   = EW'(BIAS);
    assign e_div    = EW'(ea) - EW'(eb) + bias_s;
    assign e_unb    = EW'(ea) - bias_s;
    assign e_half   = e_unb >>> 1;
    assign e_sqrt   = e_half + bias_s;
    assign x_sqrt   = e_unb[0] ? {ma, 1'b0} : {1'b0, ma};
    assign rad_init = {x_sqrt, {(MANT_W + 4){1'b0}}};

    // Special-operand outcome for the operation being started
    logic       is_special, sp_sign;
    logic [1:0] sp_code, sp_flags;

    always_comb begin
        is_special = 1'b0;
        sp_code    = 2'b00;
        sp_flags   = 2'b00;
        sp_sign    = 1'b0;
        if (fpu_op) begin
            if (na || (sa && !za)) begin
                is_special = 1'b1; sp_code = SP_NAN; sp_flags = 2'b10;
            end else if (za) begin
                is_special = 1'b1; sp_code = SP_ZERO; sp_sign = sa;
            end else if (ia) begin
                is_special = 1'b1; sp_code = SP_INF;
            end
        end else begin
            if (na || nb || (za && zb) || (ia && ib)) begin
                is_special = 1'b1; sp_code = SP_NAN; sp_flags = 2'b10;
            end else if (ia) begin
                is_special = 1'b1; sp_code = SP_INF; sp_sign = sa ^ sb;
            end else if (zb) begin
                is_special = 1'b1; sp_code = SP_INF; sp_flags = 2'b01; sp_sign = sa ^ sb;
            end else if (za || ib) begin
                is_special = 1'b1; sp_code = SP_ZERO; sp_sign = sa ^ sb;
            end
        end
    end

    // One restoring step: divide compares against the divisor, sqrt against {root, 01}
    logic [RW-1:0] rem_sh, trial, rem_sub, rem_step;
    logic [QW-1:0] q_step;
    logic          ge;

    assign rem_sh   = op_q ? {rem_q[RW-3:0], rad_q[DW-1 -: 2]} : rem_q;
    assign trial    = op_q ? {1'b0, q_q, 2'b01} : RW'(divisor_q);
    assign ge       = (rem_sh >= trial);
    assign rem_sub  = ge ? (rem_sh - trial) : rem_sh;
    assign rem_step = op_q ? rem_sub : {rem_sub[RW-2:0], 1'b0};
    assign q_step   = {q_q[QW-2:0], ge};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        rad_d     = rad_q;
        q_d       = q_q;
        valid_d   = valid_q;
        mant_d    = mant_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        dest_d    = dest_q;
        special_d = special_q;
        flags_d   = flags_q;
        unique case (state_q)
            IDLE: begin
                if (fpu_start) begin
                    op_d      = fpu_op;
                    dest_d    = fpu_dest;
                    divisor_d = mb;
                    q_d       = '0;
                    rem_d     = fpu_op ? '0 : RW'(ma);
                    rad_d     = rad_init;
                    mant_d    = '0;
                    if (is_special) begin
                        state_d   = DONE;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        exp_d     = '0;
                        sign_d    = sp_sign;
                        special_d = sp_code;
                        flags_d   = sp_flags;
                    end else begin
                        state_d   = CALC;
                        cnt_d     = CW'(QW);
                        exp_d     = fpu_op ? e_sqrt : e_div;
                        sign_d    = fpu_op ? sa : (sa ^ sb);
                        special_d = 2'b00;
                        flags_d   = 2'b00;
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                q_d   = q_step;
                rad_d = rad_q << 2;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    mant_d  = {q_step, |rem_step};
                end
            end
            DONE: begin
                if (divsqrt_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            rad_q     <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            mant_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            dest_q    <= '0;
            special_q <= 2'b00;
            flags_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            rad_q     <= rad_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            mant_q    <= mant_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            dest_q    <= dest_d;
            special_q <= special_d;
            flags_q   <= flags_d;
        end
    end

    assign divsqrt_valid    = valid_q;
    assign divsqrt_mantissa = mant_q;
    assign divsqrt_exponent = exp_q;
    assign divsqrt_sign     = sign_q;
    assign divsqrt_dest     = dest_q;
    assign divsqrt_special  = special_q;
    assign divsqrt_flags    = flags_q;
    assign fpu_divsqrt_busy = fpu_start | (state_q != IDLE);

endmodule
